// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM. It handles memory handshakes with a timeout and
// sets a sticky fault on an illegal opcode or on a memory timeout.
//
// state  | meaning
// FETCH  | instruction read, wait for mem_ready
// DECODE | register read and branch target compute
// MEMADR | effective address compute for lw/sw
// MEMRD  | data read, wait for mem_ready
// MEMWB  | load result to register file
// MEMWR  | data write, wait for mem_ready
// REXEC  | R-type ALU op
// RWB    | R-type writeback
// IEXEC  | nori ALU op
// IWB    | immediate writeback
// BRANCH | conditional branch resolve
// JUMP   | unconditional jump
// JSPAL  | jspal memory write plus PC update
// FAULT  | sticky error, left only through reset
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdest,
  output logic       regwrite,
  output logic       alusrca,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic [2:0] bj,
  output logic       mode,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JSPAL  = 4'd12,
    S_FAULT  = 4'd13
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_NORI  = 6'b001101;
  localparam logic [5:0] OP_BZ    = 6'b011000;
  localparam logic [5:0] OP_JSPAL = 6'b010011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic             instr_done_q, instr_done_d;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    mem_req      = 1'b0;
    iord         = 1'b0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    irwrite      = 1'b0;
    memtoreg     = 1'b0;
    regdest      = 1'b0;
    regwrite     = 1'b0;
    alusrca      = 1'b0;
    pcwrite      = 1'b0;
    pcwritecond  = 1'b0;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    pcsource     = 2'b00;
    bj           = 3'b000;
    mode         = 1'b0;
    state_d      = state_q;
    op_d         = op_q;
    fault_code_d = fault_code_q;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d      = S_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        op_d    = opcode;
        case (opcode)
          OP_R:                  state_d = S_REXEC;
          OP_LW, OP_SW:          state_d = S_MEMADR;
          OP_NORI:               state_d = S_IEXEC;
          OP_BEQ, OP_BLTZ, OP_BZ: state_d = S_BRANCH;
          OP_J:                  state_d = S_JUMP;
          OP_JSPAL:              state_d = S_JSPAL;
          default: begin
            state_d      = S_FAULT;
            fault_code_d = FC_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op_q == OP_LW) begin
          state_d = S_MEMRD;
        end else if (op_q == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d      = S_FAULT;
          fault_code_d = FC_ILLEGAL;
        end
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d      = S_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d      = S_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      S_REXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdest  = 1'b1;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        case (op_q)
          OP_BEQ:  bj = 3'b110;
          OP_BLTZ: bj = 3'b101;
          OP_BZ: begin
            bj   = 3'b001;
            mode = 1'b1;
          end
          default: bj = 3'b000;
        endcase
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        bj       = 3'b010;
        state_d  = S_FETCH;
      end
      S_JSPAL: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        bj       = 3'b011;
        pcsource = 2'b10;
        pcwrite  = mem_ready;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d      = S_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: begin
        state_d      = S_FAULT;
        fault_code_d = FC_ILLEGAL;
      end
    endcase

    // Any state change clears the counter; only memory states ever count.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (mem_req && !mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    fault_d      = (state_d == S_FAULT);
    instr_done_d = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      op_q         <= 6'b000000;
      cnt_q        <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      instr_done_q <= instr_done_d;
    end
  end

  assign state      = state_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign instr_done = instr_done_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with MEM_TIMEOUT=4: a per-cycle
// vector table followed by hand-written reset, illegal-opcode and timeout sequences.
module tb_multicycle_control;

  logic       clk, rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, iord, memread, memwrite, irwrite, memtoreg, regdest, regwrite;
  logic       alusrca, pcwrite, pcwritecond, mode, instr_done, fault;
  logic [1:0] alusrcb, aluop, pcsource, fault_code;
  logic [2:0] bj;
  logic [3:0] state;

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .memtoreg(memtoreg), .regdest(regdest), .regwrite(regwrite),
    .alusrca(alusrca), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
    .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .bj(bj), .mode(mode),
    .state(state), .instr_done(instr_done), .fault(fault), .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] stb_act;
  logic [9:0]  sel_act;
  logic [2:0]  flt_act;
  assign stb_act = {mem_req, iord, memread, memwrite, irwrite, memtoreg, regdest,
                    regwrite, alusrca, pcwrite, pcwritecond};
  assign sel_act = {alusrcb, aluop, pcsource, bj, mode};
  assign flt_act = {fault, fault_code};

  // Strobe vectors {mem_req,iord,memread,memwrite,irwrite,memtoreg,regdest,regwrite,alusrca,pcwrite,pcwritecond}
  localparam logic [10:0] SB_0   = 11'b00000000000;
  localparam logic [10:0] SB_F0  = 11'b10100000000;
  localparam logic [10:0] SB_F1  = 11'b10101000010;
  localparam logic [10:0] SB_A   = 11'b00000000100;
  localparam logic [10:0] SB_MRD = 11'b11100000000;
  localparam logic [10:0] SB_MWB = 11'b00000101000;
  localparam logic [10:0] SB_MWR = 11'b11010000000;
  localparam logic [10:0] SB_RWB = 11'b00000011000;
  localparam logic [10:0] SB_IWB = 11'b00000001000;
  localparam logic [10:0] SB_BR  = 11'b00000000101;
  localparam logic [10:0] SB_J   = 11'b00000000010;
  localparam logic [10:0] SB_JS1 = 11'b11010000010;
  // Select vectors {alusrcb,aluop,pcsource,bj,mode}
  localparam logic [9:0] SL_0    = 10'b00_00_00_000_0;
  localparam logic [9:0] SL_F    = 10'b01_00_00_000_0;
  localparam logic [9:0] SL_D    = 10'b11_00_00_000_0;
  localparam logic [9:0] SL_MA   = 10'b10_00_00_000_0;
  localparam logic [9:0] SL_RX   = 10'b00_10_00_000_0;
  localparam logic [9:0] SL_IX   = 10'b10_11_00_000_0;
  localparam logic [9:0] SL_BEQ  = 10'b00_01_01_110_0;
  localparam logic [9:0] SL_BLTZ = 10'b00_01_01_101_0;
  localparam logic [9:0] SL_BZ   = 10'b00_01_01_001_1;
  localparam logic [9:0] SL_J    = 10'b00_00_10_010_0;
  localparam logic [9:0] SL_JS   = 10'b00_00_10_011_0;

  localparam logic [5:0] X = 6'b111111;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [10:0] stb;
    logic [9:0]  sel;
    logic        done;
    logic [2:0]  flt;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(string n, logic [5:0] op, logic rdy, logic [3:0] st,
                              logic [10:0] stb, logic [9:0] sel, logic done, logic [2:0] flt);
    vec_t v;
    v.name = n; v.op = op; v.rdy = rdy; v.st = st;
    v.stb = stb; v.sel = sel; v.done = done; v.flt = flt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    tbl.push_back(mk("lw_f0",  X, 1'b0, 4'd0, SB_F0, SL_F, 1'b0, 3'b000));
    tbl.push_back(mk("lw_f1",  X, 1'b0, 4'd0, SB_F0, SL_F, 1'b0, 3'b000));
    tbl.push_back(mk("lw_f2",  X, 1'b1, 4'd0, SB_F1, SL_F, 1'b0, 3'b000));
    tbl.push_back(mk("lw_dec", 6'b100011, 1'b1, 4'd1, SB_0, SL_D, 1'b0, 3'b000));
    tbl.push_back(mk("lw_adr", X, 1'b0, 4'd2, SB_A, SL_MA, 1'b0, 3'b000));
    tbl.push_back(mk("lw_rd",  X, 1'b1, 4'd3, SB_MRD, SL_0, 1'b0, 3'b000));
    tbl.push_back(mk("lw_wb",  X, 1'b1, 4'd4, SB_MWB, SL_0, 1'b0, 3'b000));
    tbl.push_back(mk("lw_ret", X, 1'b1, 4'd0, SB_F1, SL_F, 1'b1, 3'b000));
    tbl.push_back(mk("r_dec",  6'b000000, 1'b0, 4'd1, SB_0, SL_D, 1'b0, 3'b000));
    tbl.push_back(mk("r_ex",   X, 1'b1, 4'd6, SB_A, SL_RX, 1'b0, 3'b000));
    tbl.push_back(mk("r_wb",   X, 1'b1, 4'd7, SB_RWB, SL_0, 1'b0, 3'b000));
    tbl.push_back(mk("r_ret",  X, 1'b1, 4'd0, SB_F1, SL_F, 1'b1, 3'b000));
    tbl.push_back(mk("ni_dec", 6'b001101, 1'b1, 4'd1, SB_0, SL_D, 1'b0, 3'b000));
    tbl.push_back(mk("ni_ex",  X, 1'b0, 4'd8, SB_A, SL_IX, 1'b0, 3'b000));
    tbl.push_back(mk("ni_wb",  X, 1'b1, 4'd9, SB_IWB, SL_0, 1'b0, 3'b000));
    tbl.push_back(mk("ni_ret", X, 1'b1, 4'd0, SB_F1, SL_F, 1'b1, 3'b000));
    tbl.push_back(mk("beq_dec", 6'b000100, 1'b0, 4'd1, SB_0, SL_D, 1'b0, 3'b000));
    tbl.push_back(mk("beq_br", X, 1'b1, 4'd10, SB_BR, SL_BEQ, 1'b0, 3'b000));
    tbl.push_back(mk("beq_ret", X, 1'b1, 4'd0, SB_F1, SL_F, 1'b1, 3'b000));
    tbl.push_back(mk("bz_dec", 6'b011000, 1'b0, 4'd1, SB_0, SL_D, 1'b0, 3'b000));
    tbl.push_back(mk("bz_br",  X, 1'b0, 4'd10, SB_BR, SL_BZ, 1'b0, 3'b000));
    tbl.push_back(mk("bz_ret", X, 1'b1, 4'd0, SB_F1, SL_F, 1'b1, 3'b000));
    tbl.push_back(mk("bl_dec", 6'b000001, 1'b0, 4'd1, SB_0, SL_D, 1'b0, 3'b000));
    tbl.push_back(mk("bl_br",  X, 1'b0, 4'd10, SB_BR, SL_BLTZ, 1'b0, 3'b000));
    tbl.push_back(mk("bl_ret", X, 1'b1, 4'd0, SB_F1, SL_F, 1'b1, 3'b000));
    tbl.push_back(mk("j_dec",  6'b000010, 1'b0, 4'd1, SB_0, SL_D, 1'b0, 3'b000));
    tbl.push_back(mk("j_jmp",  X, 1'b0, 4'd11, SB_J, SL_J, 1'b0, 3'b000));
    tbl.push_back(mk("j_ret",  X, 1'b1, 4'd0, SB_F1, SL_F, 1'b1, 3'b000));
    tbl.push_back(mk("js_dec", 6'b010011, 1'b0, 4'd1, SB_0, SL_D, 1'b0, 3'b000));
    tbl.push_back(mk("js_w0",  X, 1'b0, 4'd12, SB_MWR, SL_JS, 1'b0, 3'b000));
    tbl.push_back(mk("js_w1",  X, 1'b1, 4'd12, SB_JS1, SL_JS, 1'b0, 3'b000));
    tbl.push_back(mk("js_ret", X, 1'b1, 4'd0, SB_F1, SL_F, 1'b1, 3'b000));
    // sw where ready arrives exactly when the counter hits the timeout value
    tbl.push_back(mk("sw_dec", 6'b101011, 1'b0, 4'd1, SB_0, SL_D, 1'b0, 3'b000));
    tbl.push_back(mk("sw_adr", 6'b100011, 1'b0, 4'd2, SB_A, SL_MA, 1'b0, 3'b000));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk($sformatf("sw_wait%0d", i), X, 1'b0, 4'd5, SB_MWR, SL_0, 1'b0, 3'b000));
    tbl.push_back(mk("sw_last", X, 1'b1, 4'd5, SB_MWR, SL_0, 1'b0, 3'b000));
    tbl.push_back(mk("sw_ret", X, 1'b1, 4'd0, SB_F1, SL_F, 1'b1, 3'b000));
    // sw that never sees ready
    tbl.push_back(mk("to_dec", 6'b101011, 1'b0, 4'd1, SB_0, SL_D, 1'b0, 3'b000));
    tbl.push_back(mk("to_adr", X, 1'b0, 4'd2, SB_A, SL_MA, 1'b0, 3'b000));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk($sformatf("to_wait%0d", i), X, 1'b0, 4'd5, SB_MWR, SL_0, 1'b0, 3'b000));
    tbl.push_back(mk("to_flt0", X, 1'b1, 4'd13, SB_0, SL_0, 1'b0, 3'b110));
    tbl.push_back(mk("to_flt1", X, 1'b0, 4'd13, SB_0, SL_0, 1'b0, 3'b110));
    tbl.push_back(mk("to_flt2", X, 1'b1, 4'd13, SB_0, SL_0, 1'b0, 3'b110));

    rst_n = 1'b0;
    opcode = 6'b000000;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_fault", 16'(flt_act), 16'd0);
    chk("rst_done", 16'(instr_done), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      opcode = tbl[i].op;
      mem_ready = tbl[i].rdy;
      #1;
      chk({tbl[i].name, "_state"}, 16'(state), 16'(tbl[i].st));
      chk({tbl[i].name, "_stb"}, 16'(stb_act), 16'(tbl[i].stb));
      chk({tbl[i].name, "_sel"}, 16'(sel_act), 16'(tbl[i].sel));
      chk({tbl[i].name, "_done"}, 16'(instr_done), 16'(tbl[i].done));
      chk({tbl[i].name, "_flt"}, 16'(flt_act), 16'(tbl[i].flt));
      @(negedge clk);
    end

    // Async reset out of FAULT, then an illegal opcode
    #2 rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("flt_rst_state", 16'(state), 16'd0);
    chk("flt_rst_fault", 16'(flt_act), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("first_fetch_stb", 16'(stb_act), 16'(SB_F1));
    chk("first_fetch_sel", 16'(sel_act), 16'(SL_F));
    @(negedge clk);
    opcode = 6'b111111;
    #1;
    chk("ill_dec_state", 16'(state), 16'd1);
    @(negedge clk);
    opcode = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0];
      #1;
      chk("ill_state", 16'(state), 16'd13);
      chk("ill_flt", 16'(flt_act), 16'b101);
      chk("ill_stb", 16'(stb_act), 16'(SB_0));
      @(negedge clk);
    end

    // Reset pulsed in the middle of a JSPAL write
    do_reset();
    mem_ready = 1'b1;
    @(negedge clk);
    opcode = 6'b010011;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("js_mid_state", 16'(state), 16'd12);
    chk("js_mid_memwrite", 16'(memwrite), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("js_rst_state", 16'(state), 16'd0);
    chk("js_rst_memwrite", 16'(memwrite), 16'd0);
    chk("js_rst_pcwrite", 16'(pcwrite), 16'd0);
    chk("js_rst_fault", 16'(flt_act), 16'd0);
    @(negedge clk);
    chk("js_hold_stb", 16'(stb_act), 16'(SB_F0));
    rst_n = 1'b1;

    // FETCH with no ready: four counting cycles, then timeout on the fifth
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("ft_wait%0d_state", i), 16'(state), 16'd0);
      @(negedge clk);
    end
    #1;
    chk("ft_to_state", 16'(state), 16'd13);
    chk("ft_to_flt", 16'(flt_act), 16'b110);
    chk("ft_to_stb", 16'(stb_act), 16'(SB_0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready per memory access; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of the wait counter; SHALL satisfy 2^CNT_W > MEM_TIMEOUT.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 opcode  in  6  instruction opcode; sampled only in DECODE.
REQ-007 mem_ready  in  1  memory completion for the current mem_req cycle.
REQ-008 mem_req  out  1  memory access request, held until mem_ready.
REQ-009 iord, memread, memwrite, irwrite, memtoreg, regdest, regwrite, alusrca, pcwrite, pcwritecond  out  1 each  datapath strobes.
REQ-010 alusrcb  out  2  ALU B select; aluop  out  2  ALU op class; pcsource  out  2  PC mux select.
REQ-011 bj  out  3  branch/jump type; mode  out  1  bz zero-test mode.
REQ-012 state  out  4  current state code; instr_done  out  1  one-cycle retire pulse.
REQ-013 fault  out  1  sticky fault flag; fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.

Function
REQ-014 Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bltz 000001, nori 001101, bz 011000, jspal 010011, j 000010; all other opcodes are illegal.
REQ-015 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, IEXEC 8, IWB 9, BRANCH 10, JUMP 11, JSPAL 12, FAULT 13; codes 14-15 SHALL go to FAULT with fault_code 01.
REQ-016 Strobes are decoded from state only, except irwrite, pcwrite in FETCH/JSPAL and state advance in memory states, which are additionally qualified by mem_ready; all unlisted strobes are 0.
REQ-017 FETCH: mem_req=1, memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00; irwrite=pcwrite=mem_ready; goes to DECODE on mem_ready.
REQ-018 DECODE (1 cycle): alusrca=0, alusrcb=11, aluop=00; next: R->REXEC, lw/sw->MEMADR, nori->IEXEC, beq/bltz/bz->BRANCH, j->JUMP, jspal->JSPAL, illegal->FAULT.
REQ-019 MEMADR: alusrca=1, alusrcb=10, aluop=00; lw->MEMRD, sw->MEMWR (opcode captured in DECODE).
REQ-020 MEMRD: mem_req=1, memread=1, iord=1; MEMWB on mem_ready. MEMWB: regwrite=1, memtoreg=1, regdest=0; then FETCH.
REQ-021 MEMWR: mem_req=1, memwrite=1, iord=1; FETCH on mem_ready.
REQ-022 REXEC: alusrca=1, alusrcb=00, aluop=10; RWB: regwrite=1, regdest=1, memtoreg=0; then FETCH.
REQ-023 IEXEC: alusrca=1, alusrcb=10, aluop=11; IWB: regwrite=1, regdest=0; then FETCH.
REQ-024 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01; bj=110 beq, 101 bltz, 001 bz; mode=1 for bz only; then FETCH.
REQ-025 JUMP: pcwrite=1, pcsource=10, bj=010; then FETCH.
REQ-026 JSPAL: mem_req=1, memwrite=1, iord=1, bj=011, pcsource=10, pcwrite=mem_ready; FETCH on mem_ready.
REQ-027 instr_done is 1 for exactly the cycle a state transitions into FETCH from a non-FETCH state (not after reset and not from FAULT).
REQ-028 Wait counter clears on entering any memory state (FETCH, MEMRD, MEMWR, JSPAL) and increments each cycle mem_req=1 and mem_ready=0; when it equals MEM_TIMEOUT with mem_ready=0, next state is FAULT with fault_code 10.
REQ-029 mem_ready on the cycle the counter reaches MEM_TIMEOUT completes the access normally (ready wins over timeout).
REQ-030 mem_ready while mem_req=0 SHALL be ignored.
REQ-031 FAULT: all strobes 0, fault=1, fault_code held; exits only via reset.

Reset
REQ-032 rst_n=0 asynchronously forces state=FETCH, wait counter=0, captured opcode=000000, fault=0, fault_code=00, instr_done=0.
REQ-033 After reset release, first cycle presents FETCH outputs (mem_req=1, memread=1, alusrcb=01); reset mid-access abandons the access with no write strobe in the following cycle.

Verification
REQ-034 lw, mem_ready low 2 cycles in FETCH then high -> states 0,0,0,1,2,3,4,0; irwrite=1 only in third cycle; instr_done=1 on return to FETCH.
REQ-035 beq opcode 000100 -> BRANCH with pcwritecond=1, bj=110, aluop=01, pcsource=01, mode=0; bz 011000 -> bj=001, mode=1.
REQ-036 MEM_TIMEOUT=4, mem_ready held 0 in MEMWR -> FAULT after 4 wait cycles; fault=1, fault_code=10, memwrite=0 thereafter.
REQ-037 opcode 111111 in DECODE -> state 13, fault_code=01; persists until rst_n=0.
REQ-038 rst_n pulsed low mid JSPAL -> state=0, fault=0, memwrite=0, pcwrite=0 immediately (asynchronous).
REQ-039 MEM_TIMEOUT=4, mem_ready=1 on the 4th wait cycle -> access completes, no fault.
